maze_mem_arbiter: RTL and testbench

Arbiter and scheduler for the single-port maze tile memory (40x30 tiles of 16x16 px, 1200 entries) shared by the VGA scanout path and the game-logic writer inside `vga_maze_top`. Scanout reads have absolute priority every cycle. Game-logic writes are buffered in a small FIFO and drained only in cycles without a scanout read. With VBLANK_ONLY set, writes drain only during vertical blanking, so a frame never shows a half-updated maze. A one-cycle commit pulse tells game logic that all queued updates for the frame have landed.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/maze_wr_fifo.sv | 78 +++++++
 rtl/maze_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_maze_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA maze design: tile-map geometry, tile codes
// and the memory-arbiter state type.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int TILE_COLS  = 40;
    localparam int TILE_ROWS  = 30;
    localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 4;

    localparam logic [DATA_W-1:0] TILE_FLOOR  = 4'h0;
    localparam logic [DATA_W-1:0] TILE_WALL   = 4'h1;
    localparam logic [DATA_W-1:0] TILE_PLAYER = 4'h2;
    localparam logic [DATA_W-1:0] TILE_GOAL   = 4'h3;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/maze_wr_fifo.sv
// -----------------------------------------------------------------------------
// maze_wr_fifo
// Synchronous FIFO for buffered tile writes. Storage and pointers are
// registered; rdata always shows the registered head entry.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push, wdata   enqueue (ignored when full)
//   pop           dequeue head (ignored when empty)
//   rdata         head entry
//   full, empty   status from the registered count
//   count         number of stored entries
// -----------------------------------------------------------------------------
module maze_wr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 15,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A slot freed by a pop only becomes pushable in the following cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// -----------------------------------------------------------------------------
// maze_mem_arbiter
// Arbitrates the single-port maze tile memory between scanout reads (always
// served the cycle they are requested) and buffered game-logic writes, which
// drain only in cycles without a scanout read (and, with VBLANK_ONLY, only
// during vertical blanking). o_frame_commit pulses once per vblank when the
// write queue has fully drained.
//
// State table:
//   state  | meaning
//   ACTIVE | visible frame; writes queue up (held when VBLANK_ONLY=1)
//   DRAIN  | vblank, queue still holds entries awaiting write-out
//   DONE   | vblank, queue emptied and commit already signalled
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   i_vblank                     vertical blanking indicator
//   i_sc_req/i_sc_addr           scanout read request and tile address
//   o_sc_data/o_sc_valid         scanout data, 2 cycles after request
//   i_wr_valid/addr/data         writer request, accepted when o_wr_ready
//   o_wr_ready                   write queue has space
//   o_mem_addr/we/wdata          registered memory port
//   i_mem_rdata                  memory read data (1-cycle synchronous read)
//   o_frame_commit               one-cycle pulse: queue drained this vblank
// -----------------------------------------------------------------------------
module maze_mem_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter bit VBLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vblank,
    input  logic              i_sc_req,
    input  logic [ADDR_W-1:0] i_sc_addr,
    output logic [DATA_W-1:0] o_sc_data,
    output logic              o_sc_valid,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_frame_commit
);

    import vga_pkg::*;

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              sc_v1_q, sc_v1_d;
    logic              sc_v2_q, sc_v2_d;
    logic              commit_q, commit_d;

    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_end;
    logic              push_acc;
    logic              pop;
    logic              drain_en;

    assign {head_addr, head_data} = head;

    // Held low while reset is asserted even though the queue reads empty.
    assign o_wr_ready = rst && !fifo_full;
    assign push_acc   = i_wr_valid && o_wr_ready;
    assign drain_en   = !VBLANK_ONLY || (state_q != ACTIVE);
    assign pop        = !i_sc_req && !fifo_empty && drain_en;
    // Occupancy as it will stand after this cycle's push and pop.
    assign count_end  = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);

    maze_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc),
        .wdata ({i_wr_addr, i_wr_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (i_sc_req) begin
            mem_addr_d = i_sc_addr;
        end else if (pop) begin
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
            mem_we_d    = 1'b1;
        end

        sc_v1_d = i_sc_req;
        sc_v2_d = sc_v1_q;

        state_d  = state_q;
        commit_d = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (i_vblank) state_d = DRAIN;
            end
            DRAIN: begin
                // Vblank ending wins: leftover entries wait for the next one.
                if (!i_vblank) begin
                    state_d = ACTIVE;
                end else if (count_end == '0) begin
                    state_d  = DONE;
                    commit_d = 1'b1;
                end
            end
            DONE: begin
                if (!i_vblank) state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ACTIVE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            sc_v1_q     <= 1'b0;
            sc_v2_q     <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            sc_v1_q     <= sc_v1_d;
            sc_v2_q     <= sc_v2_d;
            commit_q    <= commit_d;
        end
    end

    assign o_mem_addr     = mem_addr_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_frame_commit = commit_q;
    assign o_sc_valid     = sc_v2_q;
    // Pass-through of the memory read data, forced to 0 when not valid.
    assign o_sc_data      = sc_v2_q ? i_mem_rdata : '0;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maze_mem_arbiter
// Randomized bench for maze_mem_arbiter with a queue-based reference model
// and a behavioural tile memory.
// -----------------------------------------------------------------------------
module tb_maze_mem_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam bit VBO   = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vblank;
    logic          i_sc_req;
    logic [AW-1:0] i_sc_addr;
    logic [DW-1:0] o_sc_data;
    logic          o_sc_valid;
    logic          i_wr_valid;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_ready;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          o_frame_commit;

    maze_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .VBLANK_ONLY (VBO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_vblank       (i_vblank),
        .i_sc_req       (i_sc_req),
        .i_sc_addr      (i_sc_addr),
        .o_sc_data      (o_sc_data),
        .o_sc_valid     (o_sc_valid),
        .i_wr_valid     (i_wr_valid),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .o_wr_ready     (o_wr_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_we       (o_mem_we),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata),
        .o_frame_commit (o_frame_commit)
    );

    always #20 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ {a[10:8], 1'b1};
    endfunction

    // Behavioural single-port memory, synchronous read.
    logic [DW-1:0] phys_mem [2048];
    bit            phys_ok  [2048];
    logic [DW-1:0] rdata_q = '0;

    always @(posedge clk) begin
        rdata_q <= phys_ok[o_mem_addr] ? phys_mem[o_mem_addr] : init_val(o_mem_addr);
        if (o_mem_we) begin
            phys_mem[o_mem_addr] <= o_mem_wdata;
            phys_ok[o_mem_addr]  <= 1'b1;
        end
    end
    assign i_mem_rdata = rdata_q;

    // Reference model
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] ref_mem [2048];
    wr_t           wq[$];
    bit            prev_vb;
    bit            committed;
    bit            e_we, e_commit;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            sc1_v, sc2_v;
    logic [DW-1:0] sc1_d, sc2_d;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check the outputs of the current cycle, apply new
    // inputs, advance the model to produce next cycle's expectations.
    task automatic step(input bit r, input bit vb, input bit sc, input logic [AW-1:0] sa,
                        input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit  ready;
        bit  in_vb;
        wr_t h;
        check("mem_we", o_mem_we, e_we);
        check("mem_addr", o_mem_addr, e_addr);
        if (e_we) check("mem_wdata", o_mem_wdata, e_wdata);
        check("frame_commit", o_frame_commit, e_commit);
        check("sc_valid", o_sc_valid, sc2_v);
        if (sc2_v) check("sc_data", o_sc_data, sc2_d);

        rst        = r;
        i_vblank   = vb;
        i_sc_req   = sc;
        i_sc_addr  = sa;
        i_wr_valid = wv;
        i_wr_addr  = wa;
        i_wr_data  = wd;
        #1;
        ready = r && (wq.size() < DEPTH);
        check("wr_ready", o_wr_ready, ready);

        if (!r) begin
            wq.delete();
            prev_vb   = 1'b0;
            committed = 1'b0;
            e_we      = 1'b0;
            e_addr    = '0;
            e_wdata   = '0;
            e_commit  = 1'b0;
            sc1_v     = 1'b0;
            sc2_v     = 1'b0;
        end else begin
            sc2_v = sc1_v;
            sc2_d = sc1_d;
            sc1_v = sc;
            sc1_d = ref_mem[sa];
            in_vb    = prev_vb;
            e_we     = 1'b0;
            e_commit = 1'b0;
            if (sc) begin
                e_addr = sa;
            end else if ((!VBO || in_vb) && wq.size() > 0) begin
                h       = wq.pop_front();
                e_we    = 1'b1;
                e_addr  = h.a;
                e_wdata = h.d;
                ref_mem[h.a] = h.d;
            end
            if (wv && ready) wq.push_back({wa, wd});
            if (!in_vb) begin
                committed = 1'b0;
            end else if (vb && !committed && wq.size() == 0) begin
                e_commit  = 1'b1;
                committed = 1'b1;
            end
            prev_vb = vb;
        end
        @(negedge clk);
    endtask

    int  p_sc  [7] = '{100,  0, 50, 90, 20, 50, 30};
    int  p_wr  [7] = '{  0, 80, 60, 90, 100, 50, 40};
    int  p_rst [7] = '{  0,  0,  0,  0,  0,  2,  1};

    initial begin
        bit vb;
        int vb_left;
        bit r;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(AW'(i));
        rst = 1'b0; i_vblank = 1'b0; i_sc_req = 1'b0; i_sc_addr = '0;
        i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        prev_vb = 1'b0; committed = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        e_commit = 1'b0; sc1_v = 1'b0; sc2_v = 1'b0; sc1_d = '0; sc2_d = '0;
        repeat (3) @(negedge clk);

        // Sequential scanout of the first tile row.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, AW'(i), 1'b0, '0, '0);
        // Single write held until vblank, then vblank with no scanout.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, AW'(5), 4'hA);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        repeat (2) step(1'b1, 1'b0, 1'b1, AW'(5), 1'b0, '0, '0);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);

        vb = 1'b0;
        vb_left = 5;
        for (int ph = 0; ph < 7; ph++) begin
            for (int c = 0; c < 350; c++) begin
                if (vb_left == 0) begin
                    vb = !vb;
                    vb_left = vb ? $urandom_range(1, 12) : $urandom_range(3, 25);
                end
                vb_left--;
                r = !($urandom_range(0, 99) < p_rst[ph]);
                step(r, vb,
                     $urandom_range(0, 99) < p_sc[ph], AW'($urandom_range(0, 1199)),
                     $urandom_range(0, 99) < p_wr[ph], AW'($urandom_range(0, 1199)),
                     DW'($urandom));
            end
        end
        repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
